bitwise: RTL and testbench

Registered bitwise logic unit: combines two equal-width operand vectors with a selectable bitwise operator and also produces a one-bit "result non-zero" flag. It is a small datapath leaf used wherever a masked or merged bit vector and an any-bit-set indication are needed on the same clock. The default configuration is 3-bit operands and a bitwise AND.

---
 rtl/bitwise_pkg.sv | 15 +
 rtl/bitwise_core.sv | 37 +++
 rtl/bitwise.sv | 49 ++++
 tb/tb_bitwise.sv | 122 ++++++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// bitwise_pkg: shared definitions for the bitwise logic unit.
//   op_e          - 2-bit operator encoding carried on the op port
//   DEFAULT_WIDTH - operand/result width used when WIDTH is not overridden
package bitwise_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } op_e;

  localparam int DEFAULT_WIDTH = 3;

endpackage : bitwise_pkg

// File: rtl/bitwise_core.sv
// bitwise_core: purely combinational per-bit operator plus any-bit-set flag.
// Ports:
//   x  [WIDTH-1:0] in  - operand A
//   y  [WIDTH-1:0] in  - operand B
//   op [1:0]       in  - operator select (op_e encoding)
//   r  [WIDTH-1:0] out - per-bit result
//   f              out - OR-reduction of r
module bitwise_core
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] r,
  output logic             f
);

  op_e op_sel;

  assign op_sel = op_e'(op);

  always_comb begin
    r = '0;
    unique case (op_sel)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_XNOR: r = ~(x ^ y);
      default: r = '0;
    endcase
  end

  assign f = |r;

endmodule : bitwise_core

// File: rtl/bitwise.sv
// bitwise: registered bitwise logic unit, 1-cycle latency, one result per cycle.
// Ports:
//   clk            in  - clock, rising edge
//   rst_n          in  - synchronous active-low reset (clears z and o)
//   x  [WIDTH-1:0] in  - operand A
//   y  [WIDTH-1:0] in  - operand B
//   op [1:0]       in  - operator select, tie to 2'b00 (AND) when unused
//   z  [WIDTH-1:0] out - registered result
//   o              out - registered flag, |z
module bitwise
  import bitwise_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] z,
  output logic             o
);

  logic [WIDTH-1:0] r;
  logic             f;

  bitwise_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .x  (x),
    .y  (y),
    .op (op),
    .r  (r),
    .f  (f)
  );

  // Flag is registered from the same combinational result so z and o never
  // disagree on any cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z <= '0;
      o <= 1'b0;
    end else begin
      z <= r;
      o <= f;
    end
  end

endmodule : bitwise

// File: tb/tb_bitwise.sv
module tb_bitwise;

  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [1:0]   op;
  logic [W-1:0] z;
  logic         o;

  int n_vec;
  int n_miss;

  bitwise #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y),
    .op    (op),
    .z     (z),
    .o     (o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: value-level view of each operator, result confined to W bits.
  function automatic int ref_z(input int a, input int b, input int sel, input bit rst);
    int mask;
    int res;
    mask = (1 << W) - 1;
    if (rst) return 0;
    case (sel)
      0:       res = a & b;
      1:       res = a | b;
      2:       res = a ^ b;
      default: res = ~(a ^ b);
    endcase
    return res & mask;
  endfunction

  // Drive one vector, clock once, sample 1 time unit after the edge.
  task automatic apply(input string tag, input int a, input int b, input int sel,
                       input bit rst);
    int ez;
    x     = W'(a);
    y     = W'(b);
    op    = 2'(sel);
    rst_n = ~rst;
    @(posedge clk);
    #1;
    ez = ref_z(a, b, sel, rst);
    check_val({tag, ".z"}, 32'(z), 32'(ez));
    check_val({tag, ".o"}, 32'(o), 32'(ez != 0));
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    x      = '1;
    y      = '1;
    op     = 2'b00;

    // Reset held for two edges with all-ones operands.
    @(posedge clk);
    apply("reset", 7, 7, 0, 1'b1);
    check_val("reset.z_const", 32'(z), 32'd0);

    // Default AND cases, back to back.
    apply("and_disjoint", 3'b011, 3'b100, 0, 1'b0);
    check_val("and_disjoint.z_const", 32'(z), 32'd0);
    apply("and_75", 7, 5, 0, 1'b0);
    check_val("and_75.z_const", 32'(z), 32'd5);
    apply("and_01", 0, 1, 0, 1'b0);
    apply("and_33", 3, 3, 0, 1'b0);
    check_val("and_33.z_const", 32'(z), 32'd3);

    // Operator sweep.
    apply("or_sweep", 3'b110, 3'b011, 1, 1'b0);
    check_val("or_sweep.z_const", 32'(z), 32'd7);
    apply("xor_sweep", 3'b110, 3'b011, 2, 1'b0);
    check_val("xor_sweep.z_const", 32'(z), 32'd5);
    apply("xnor_sweep", 3'b110, 3'b011, 3, 1'b0);
    check_val("xnor_sweep.z_const", 32'(z), 32'd2);
    apply("xnor_zero", 7, 0, 3, 1'b0);
    check_val("xnor_zero.o_const", 32'(o), 32'd0);

    // Mid-stream reset discards the in-flight result, then recovery.
    apply("mid_rst", 7, 7, 0, 1'b1);
    check_val("mid_rst.z_const", 32'(z), 32'd0);
    apply("post_rst", 7, 7, 0, 1'b0);
    check_val("post_rst.z_const", 32'(z), 32'd7);

    // Randomized stream with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      int a;
      int b;
      int sel;
      bit rst;
      a   = int'($urandom_range(0, (1 << W) - 1));
      b   = int'($urandom_range(0, (1 << W) - 1));
      sel = int'($urandom_range(0, 3));
      rst = ($urandom_range(0, 15) == 0);
      apply("rand", a, b, sel, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_bitwise
